param_serializer: RTL and testbench
===================================

Name: param_serializer

Overview:
- Parametrised successor to the team's 16-bit serializer.
- Accepts one parallel word of DATA_W bits with a runtime length field and a runtime bit-order select, and shifts it out one bit per clock.
- Adds back-to-back streaming: the next word can be accepted during the last bit of the current word, with zero idle cycles between words.
- Sits between a parallel packet source and a single-bit line driver; it is wrapped by the usual input/output register wrapper.

Parameters:
- DATA_W, 16, parallel word width; must be a power of two and at least 4.
- MOD_W, $clog2(DATA_W), width of the length field; derived, do not override.
- MIN_BITS, 3, smallest legal nonzero length; lengths 1..MIN_BITS-1 are rejected.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- i_arst_n  input  1  asynchronous active-low reset.
- i_data  input  DATA_W  parallel word.
- i_data_mod  input  MOD_W  number of bits to send; 0 means DATA_W.
- i_data_val  input  1  word valid, single-cycle qualifier.
- i_msb_first  input  1  bit order: 1 = MSB first, 0 = LSB first; sampled with the word.
- o_ser_data  output  1  serial bit.
- o_ser_data_val  output  1  o_ser_data is valid this cycle.
- o_busy  output  1  high = a word presented now is ignored.

Behaviour:
- Reset is asynchronous, active-low. While i_arst_n=0, all outputs are 0 immediately, the shift register and bit counter are cleared, and the state is IDLE. Release is synchronous to clk.
- A word is accepted at a rising edge when all of the following hold:
  - i_data_val=1,
  - o_busy=0,
  - the length L is legal. L = DATA_W if i_data_mod=0, else L = i_data_mod; legal means L >= MIN_BITS.
- A word with illegal L (1..MIN_BITS-1) is dropped: no output, and the state does not change.
- i_data_val=1 while o_busy=1 is ignored. Nothing is queued.
- State machine IDLE/SHIFT:
  - IDLE -> SHIFT on accept.
  - SHIFT -> IDLE after the last bit, unless a new word is accepted on that same edge, in which case stay in SHIFT.
- Latency: the first bit appears on the outputs in the cycle immediately after the accepting edge. o_ser_data_val=1 for exactly L consecutive cycles.
- Bit order for a word of length L:
  - MSB first: i_data[DATA_W-1], i_data[DATA_W-2], ..., i_data[DATA_W-L].
  - LSB first: i_data[0], i_data[1], ..., i_data[L-1].
- i_data, i_data_mod and i_msb_first are captured at acceptance. Later changes have no effect on a word in progress.
- o_busy = 1 during SHIFT for every bit except the last. During the last bit o_busy=0, so a word presented in that cycle is accepted and its first bit follows with no gap.
- o_ser_data = 0 whenever o_ser_data_val = 0.
- Bit counter is MOD_W+1 bits wide so it can hold DATA_W. It loads L on accept and decrements each cycle; the last bit is the cycle where counter = 1.
- Reset asserted mid-word aborts the word; no further bits are output after release.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset, then i_data=16'hA5F0, mod=0, msb_first=1, one-cycle val -> bits 1010_0101_1111_0000 over 16 cycles starting the cycle after accept. o_ser_data_val high for 16 cycles; o_busy high for the first 15.
- i_data=16'h000B, mod=4, msb_first=0 -> bits 1,1,0,1 over 4 cycles, then val=0 and o_ser_data=0.
- mod=1 and mod=2 with val=1 -> no output, o_busy stays 0. Then mod=3, i_data=16'hE000, msb_first=1 -> bits 1,1,1.
- Back-to-back: word A (mod=5) followed by word B (mod=3), with B presented during A's 5th bit -> 8 contiguous valid cycles, no gap. A val pulse during A's 3rd bit must be ignored.
- Drive i_arst_n=0 mid-word (after bit 7 of 16) -> all outputs 0 without waiting for a clock edge. After release, outputs stay idle until a new val; the next word serialises correctly.
- DATA_W=32 instance: mod=0, i_data=32'h8000_0001, msb_first=0 -> bit 1, then 30 zeros, then bit 1, over 32 cycles.

Source files
------------

// File: rtl/param_serializer.sv
// Parallel-to-serial shifter: one DATA_W word in, L bits out (L set per word), MSB- or LSB-first.
// Latency: first bit is on the outputs the cycle after the accepting edge; val is high for exactly L cycles.
// Backpressure: o_busy is high for every bit except the last. Words offered while busy, or with a
//   length below MIN_BITS, are dropped. Nothing is queued.
//
// Ports:
//   clk            rising-edge clock
//   i_arst_n       asynchronous active-low reset
//   i_data         parallel word, captured on accept
//   i_data_mod     bit count to send; 0 means DATA_W
//   i_data_val     single-cycle word qualifier
//   i_msb_first    1 = MSB first, 0 = LSB first; captured on accept
//   o_ser_data     serial bit; 0 whenever o_ser_data_val is low
//   o_ser_data_val serial bit is valid this cycle
//   o_busy         high = a word offered now is ignored
module param_serializer #(
   parameter int DATA_W   = 16,
   parameter int MOD_W    = $clog2(DATA_W),
   parameter int MIN_BITS = 3
) (
   input  logic              clk,
   input  logic              i_arst_n,
   input  logic [DATA_W-1:0] i_data,
   input  logic [MOD_W-1:0]  i_data_mod,
   input  logic              i_data_val,
   input  logic              i_msb_first,
   output logic              o_ser_data,
   output logic              o_ser_data_val,
   output logic              o_busy
);

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   // The counter is one bit wider than the length field so it can hold DATA_W itself.
   localparam logic [MOD_W:0] CNT_FULL = DATA_W[MOD_W:0];
   localparam logic [MOD_W:0] CNT_MIN  = MIN_BITS[MOD_W:0];
   localparam logic [MOD_W:0] CNT_ONE  = {{MOD_W{1'b0}}, 1'b1};

   state_t            state_q, state_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [MOD_W:0]    cnt_q, cnt_d;
   logic              val_q, val_d;
   logic              busy_q, busy_d;

   logic [MOD_W:0]    word_len;
   logic              accept;
   logic [DATA_W-1:0] load_word;

   assign word_len = (i_data_mod == '0) ? CNT_FULL : {1'b0, i_data_mod};
   assign accept   = i_data_val && !busy_q && (word_len >= CNT_MIN);

   // The shift register always shifts left and the line bit is its MSB. An LSB-first word is
   // bit-reversed at load time so both orders share one datapath.
   always_comb begin
      load_word = i_data;
      if (!i_msb_first) begin
         for (int i = 0; i < DATA_W; i++) begin
            load_word[DATA_W-1-i] = i_data[i];
         end
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         val_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         val_q   <= val_d;
         busy_q  <= busy_d;
      end
   end

   // Next-state logic. An accept takes priority, so a word accepted during the last bit
   // reloads the shifter on the same edge and the line never goes idle.
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      if (accept) begin
         state_d = SHIFT;
         shreg_d = load_word;
         cnt_d   = word_len;
      end else if (state_q == SHIFT) begin
         if (cnt_q == CNT_ONE) begin
            // Clearing the shifter keeps the line bit at 0 while idle.
            state_d = IDLE;
            shreg_d = '0;
            cnt_d   = '0;
         end else begin
            shreg_d = shreg_q << 1;
            cnt_d   = cnt_q - CNT_ONE;
         end
      end
   end

   // Output logic. These are computed from the next state so that valid and busy come
   // straight out of flops, in step with the shifter MSB.
   always_comb begin
      val_d  = (state_d == SHIFT);
      busy_d = (state_d == SHIFT) && (cnt_d != CNT_ONE);
   end

   assign o_ser_data     = shreg_q[DATA_W-1];
   assign o_ser_data_val = val_q;
   assign o_busy         = busy_q;

endmodule

// File: tb/tb_param_serializer.sv
// Self-checking bench for param_serializer. A 16-bit instance is checked against a queue of
// expected line bits. A 32-bit instance gets one directed word.
module tb_param_serializer;

   logic        clk = 1'b0;
   logic        arst_n;
   logic [15:0] data;
   logic [3:0]  data_mod;
   logic        data_val;
   logic        msb_first;
   logic        ser_data, ser_val, busy;

   logic [31:0] data32;
   logic [4:0]  data_mod32;
   logic        data_val32, msb_first32;
   logic        ser_data32, ser_val32, busy32;

   int errors = 0;
   int checks = 0;

   // Reference model: the bits still to appear on the line; the head is the bit on the line now.
   bit          exp_q[$];
   logic [15:0] seen;
   int          vcnt;
   int          bcnt;

   always #5 clk = ~clk;

   param_serializer #(.DATA_W(16)) dut (
      .clk(clk), .i_arst_n(arst_n), .i_data(data), .i_data_mod(data_mod),
      .i_data_val(data_val), .i_msb_first(msb_first),
      .o_ser_data(ser_data), .o_ser_data_val(ser_val), .o_busy(busy)
   );

   param_serializer #(.DATA_W(32)) dut32 (
      .clk(clk), .i_arst_n(arst_n), .i_data(data32), .i_data_mod(data_mod32),
      .i_data_val(data_val32), .i_msb_first(msb_first32),
      .o_ser_data(ser_data32), .o_ser_data_val(ser_val32), .o_busy(busy32)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int len_of(input logic [3:0] m);
      return (m == 4'd0) ? 16 : int'(m);
   endfunction

   // Compare the three outputs of the 16-bit instance with the model.
   task automatic chk_line(input string tag);
      chk({tag, "_val"},  {31'd0, ser_val},  (exp_q.size() > 0) ? 32'd1 : 32'd0);
      chk({tag, "_data"}, {31'd0, ser_data}, (exp_q.size() > 0) ? {31'd0, exp_q[0]} : 32'd0);
      chk({tag, "_busy"}, {31'd0, busy},     (exp_q.size() > 1) ? 32'd1 : 32'd0);
   endtask

   // Apply one cycle of input, advance the model across the edge, and check just after it.
   task automatic tick(input string tag, input logic v, input logic [15:0] d,
                       input logic [3:0] m, input logic msb);
      bit acc;
      int len;
      data      = d;
      data_mod  = m;
      data_val  = v;
      msb_first = msb;
      len = len_of(m);
      // A word is taken only if at most the final bit of the current word remains.
      acc = v && (exp_q.size() <= 1) && (len >= 3);
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (acc) begin
         for (int k = 0; k < len; k++) exp_q.push_back(msb ? d[15-k] : d[k]);
      end
      chk_line(tag);
      if (ser_val) begin
         seen = {seen[14:0], ser_data};
         vcnt++;
      end
      if (busy) bcnt++;
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) tick(tag, 1'b0, 16'($urandom), 4'($urandom), 1'($urandom));
   endtask

   task automatic clr_rec();
      seen = '0;
      vcnt = 0;
      bcnt = 0;
   endtask

   initial begin
      arst_n = 1'b0;
      data = '0; data_mod = '0; data_val = 1'b0; msb_first = 1'b0;
      data32 = '0; data_mod32 = '0; data_val32 = 1'b0; msb_first32 = 1'b0;
      clr_rec();

      // Reset state
      #2;
      chk_line("rst");
      chk("rst32_val",  {31'd0, ser_val32},  32'd0);
      chk("rst32_busy", {31'd0, busy32},     32'd0);
      chk("rst32_data", {31'd0, ser_data32}, 32'd0);
      #10 arst_n = 1'b1;
      idle("post_rst", 2);

      // Full word, MSB first
      clr_rec();
      tick("a5f0", 1'b1, 16'hA5F0, 4'd0, 1'b1);
      idle("a5f0", 16);
      chk("a5f0_bits", {16'd0, seen}, 32'h0000A5F0);
      chk("a5f0_vcnt", vcnt, 16);
      chk("a5f0_bcnt", bcnt, 15);

      // Four bits, LSB first
      clr_rec();
      tick("b4", 1'b1, 16'h000B, 4'd4, 1'b0);
      idle("b4", 5);
      chk("b4_bits", {28'd0, seen[3:0]}, 32'hD);
      chk("b4_vcnt", vcnt, 4);

      // Illegal lengths are dropped, the minimum legal length is sent
      clr_rec();
      tick("mod1", 1'b1, 16'hFFFF, 4'd1, 1'b1);
      tick("mod2", 1'b1, 16'hFFFF, 4'd2, 1'b0);
      chk("rej_vcnt", vcnt, 0);
      tick("e3", 1'b1, 16'hE000, 4'd3, 1'b1);
      idle("e3", 4);
      chk("e3_bits", {29'd0, seen[2:0]}, 32'h7);
      chk("e3_vcnt", vcnt, 3);

      // Back-to-back: A (5 bits), stray val during bit 3, B (3 bits) during A's last bit
      clr_rec();
      tick("b2b_a", 1'b1, 16'hB700, 4'd5, 1'b1);
      idle("b2b_a", 2);
      tick("b2b_stray", 1'b1, 16'hFFFF, 4'd0, 1'b0);
      idle("b2b_a", 1);
      tick("b2b_b", 1'b1, 16'h0005, 4'd3, 1'b0);
      idle("b2b_b", 4);
      chk("b2b_vcnt", vcnt, 8);
      chk("b2b_bits", {24'd0, seen[7:0]}, 32'hB5);

      // Asynchronous reset in the middle of a word
      tick("rst_mid", 1'b1, 16'h5A5A, 4'd0, 1'b0);
      idle("rst_mid", 7);
      #3 arst_n = 1'b0;
      #1;
      exp_q.delete();
      chk("arst_val",  {31'd0, ser_val},  32'd0);
      chk("arst_data", {31'd0, ser_data}, 32'd0);
      chk("arst_busy", {31'd0, busy},     32'd0);
      @(posedge clk);
      #2 arst_n = 1'b1;
      clr_rec();
      idle("after_rst", 4);
      chk("after_rst_vcnt", vcnt, 0);
      tick("after_rst_word", 1'b1, 16'hC3A1, 4'd9, 1'b1);
      idle("after_rst_word", 10);
      chk("after_rst_bits", {23'd0, seen[8:0]}, 32'h187);

      // Randomised traffic, including words offered on the last bit
      for (int i = 0; i < 600; i++) begin
         tick("rand", ($urandom_range(0, 2) == 0), 16'($urandom), 4'($urandom), 1'($urandom));
      end
      idle("drain", 17);

      // 32-bit instance: full length, LSB first
      data32      = 32'h8000_0001;
      data_mod32  = 5'd0;
      msb_first32 = 1'b0;
      data_val32  = 1'b1;
      @(posedge clk);
      #1;
      data_val32 = 1'b0;
      data32     = 32'hFFFF_FFFF;
      for (int k = 0; k < 32; k++) begin
         chk("w32_val",  {31'd0, ser_val32},  32'd1);
         chk("w32_data", {31'd0, ser_data32}, (k == 0 || k == 31) ? 32'd1 : 32'd0);
         chk("w32_busy", {31'd0, busy32},     (k < 31) ? 32'd1 : 32'd0);
         @(posedge clk);
         #1;
      end
      chk("w32_end_val",  {31'd0, ser_val32},  32'd0);
      chk("w32_end_data", {31'd0, ser_data32}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
